// File: rtl/tmp3_monitor.sv
// tmp3_monitor
// Periodically requests a temperature reading from a TMP3-style sensor
// interface, captures the result, tracks the signed minimum and maximum, and
// converts the latest reading into sign + BCD ({hundreds, tens, ones, tenths}).
//
// Ports
//   clk            system clock, all logic on its rising edge
//   rst            asynchronous active-high reset
//   enable         level, high runs periodic sampling
//   clear_minmax   one-cycle pulse, restarts min/max tracking
//   busy_i         sensor interface transaction in progress
//   valid_i        sensor interface read result valid (level)
//   temperature_i  12-bit two's complement, 0.0625 C/LSB
//   update_o       update request to the sensor interface
//   sample_o       last captured temperature
//   min_o / max_o  signed min / max since reset or clear
//   minmax_valid   min_o / max_o hold at least one sample
//   sign_o         displayed value is negative
//   bcd_o          {hundreds, tens, ones, tenths} of the magnitude
//   new_sample     one-cycle pulse when bcd_o / sign_o update
//   timeout_o      sticky, the last request timed out
module tmp3_monitor #(
  parameter int PERIOD  = 100000000,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_minmax,
  input  logic        busy_i,
  input  logic        valid_i,
  input  logic [11:0] temperature_i,
  output logic        update_o,
  output logic [11:0] sample_o,
  output logic [11:0] min_o,
  output logic [11:0] max_o,
  output logic        minmax_valid,
  output logic        sign_o,
  output logic [15:0] bcd_o,
  output logic        new_sample,
  output logic        timeout_o
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_READ = 3'd2,
    S_CONV = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    conv_cnt;
  logic          valid_q;
  logic          valid_rise;
  logic          capture;
  logic          tmo_hit;
  logic          conv_last;
  logic [19:0]   conv_sr;
  logic [19:0]   conv_step;
  logic          sign_pend;
  logic [3:0]    tenths_pend;
  logic [11:0]   cap_mag;

  // Absolute value as 12-bit unsigned; 0x800 maps to 2048.
  function automatic logic [11:0] magnitude(input logic [11:0] t);
    logic [11:0] m;
    if (t[11]) begin
      m = (~t) + 12'd1;
    end else begin
      m = t;
    end
    return m;
  endfunction

  // Fraction nibble (1/16 C) to truncated tenths digit.
  function automatic logic [3:0] tenths_of(input logic [3:0] frac);
    logic [7:0] p;
    p = {4'd0, frac} * 8'd10;
    return p[7:4];
  endfunction

  // One shift-add-3 iteration. Layout: [19:16] hundreds, [15:12] tens,
  // [11:8] ones, [7:0] remaining binary bits of the integer part.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int d = 0; d < 3; d++) begin
      if (t[8 + 4*d +: 4] >= 4'd5) begin
        t[8 + 4*d +: 4] = t[8 + 4*d +: 4] + 4'd3;
      end else begin
        t[8 + 4*d +: 4] = t[8 + 4*d +: 4];
      end
    end
    return {t[18:0], 1'b0};
  endfunction

  assign valid_rise = valid_i & ~valid_q;
  assign conv_step  = dabble_step(conv_sr);
  assign cap_mag    = magnitude(temperature_i);

  // Next-state logic and single-cycle event strobes.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    tmo_hit    = 1'b0;
    conv_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          next_state = S_REQ;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = S_WAIT;
        end else if (busy_i) begin
          next_state = S_READ;
        end else begin
          next_state = S_REQ;
        end
      end
      S_READ: begin
        // A result that arrives on the last allowed cycle still wins.
        if (valid_rise) begin
          capture    = 1'b1;
          next_state = S_CONV;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = S_WAIT;
        end else begin
          next_state = S_READ;
        end
      end
      S_CONV: begin
        if (conv_cnt == 3'd7) begin
          conv_last = 1'b1;
          if (enable) begin
            next_state = S_WAIT;
          end else begin
            next_state = S_IDLE;
          end
        end else begin
          next_state = S_CONV;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else if (per_cnt == PER_LAST) begin
          next_state = S_REQ;
        end else begin
          next_state = S_WAIT;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register, registered request output and valid_i history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      update_o <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= next_state;
      update_o <= (next_state == S_REQ);
      valid_q  <= valid_i;
    end
  end

  // Request timeout counter: zero on REQ entry, runs through REQ and READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (((state == S_REQ) || (state == S_READ)) &&
                 ((next_state == S_REQ) || (next_state == S_READ))) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Inter-sample period counter; cleared whenever WAIT is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if ((state == S_WAIT) && (next_state == S_WAIT)) begin
      per_cnt <= per_cnt + 1'b1;
    end else begin
      per_cnt <= '0;
    end
  end

  // Conversion cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_cnt <= 3'd0;
    end else if ((state == S_CONV) && !conv_last) begin
      conv_cnt <= conv_cnt + 3'd1;
    end else begin
      conv_cnt <= 3'd0;
    end
  end

  // Capture of the reading and preparation of the BCD conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_o    <= 12'd0;
      sign_pend   <= 1'b0;
      tenths_pend <= 4'd0;
      conv_sr     <= 20'd0;
    end else if (capture) begin
      sample_o    <= temperature_i;
      sign_pend   <= temperature_i[11];
      tenths_pend <= tenths_of(cap_mag[3:0]);
      conv_sr     <= {12'd0, cap_mag[11:4]};
    end else if (state == S_CONV) begin
      conv_sr <= conv_step;
    end else begin
      conv_sr <= conv_sr;
    end
  end

  // Display outputs; the eighth shift is taken straight from conv_step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_o      <= 16'd0;
      sign_o     <= 1'b0;
      new_sample <= 1'b0;
    end else if (conv_last) begin
      bcd_o      <= {conv_step[19:8], tenths_pend};
      sign_o     <= sign_pend;
      new_sample <= 1'b1;
    end else begin
      new_sample <= 1'b0;
    end
  end

  // Sticky timeout flag: set on abandon, cleared by the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_o <= 1'b0;
    end else if (capture) begin
      timeout_o <= 1'b0;
    end else if (tmo_hit) begin
      timeout_o <= 1'b1;
    end else begin
      timeout_o <= timeout_o;
    end
  end

  // Signed min/max tracking; a clear coinciding with a capture reloads both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_o        <= 12'd0;
      max_o        <= 12'd0;
      minmax_valid <= 1'b0;
    end else if (capture) begin
      minmax_valid <= 1'b1;
      if (clear_minmax || !minmax_valid) begin
        min_o <= temperature_i;
        max_o <= temperature_i;
      end else begin
        if ($signed(temperature_i) < $signed(min_o)) begin
          min_o <= temperature_i;
        end else begin
          min_o <= min_o;
        end
        if ($signed(temperature_i) > $signed(max_o)) begin
          max_o <= temperature_i;
        end else begin
          max_o <= max_o;
        end
      end
    end else if (clear_minmax) begin
      minmax_valid <= 1'b0;
    end else begin
      minmax_valid <= minmax_valid;
    end
  end

endmodule
